// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage (shift-add mul, restoring div).
// Define MULDIV_FAST_MUL_EN to compute MUL* ops with a single combinational multiplier.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      ALUOp,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    // Encoding: bit4:3 = 2'b10 marks M ops, bit2 selects div, bits1:0 the variant.
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              sign_a, sign_b, div0;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;

    logic              is_m, accept, in_div, in_sa, in_sb, sa, sb;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   final_val;

    assign is_m   = (ALUOp[4:3] == 2'b10);
    assign accept = start & is_m & ~flush & (state == IDLE);
    assign stall  = accept | busy;

    assign in_div = ALUOp[2];
    assign in_sa  = in_div ? ~ALUOp[0] : (ALUOp[1:0] != 2'b11);
    assign in_sb  = in_div ? ~ALUOp[0] : ~ALUOp[1];
    assign sa     = in_sa & op_a[XLEN-1];
    assign sb     = in_sb & op_b[XLEN-1];
    assign a_abs  = sa ? -op_a : op_a;
    assign b_abs  = sb ? -op_b : op_b;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                    + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mcand};
    assign div_next = div_diff[XLEN]
                    ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                    : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign prod = (sign_a ^ sign_b) ? -acc : acc;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
`endif

    always_comb begin
        final_val = '0;
        if (!op_q[2]) begin
            final_val = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                             : prod[2*XLEN-1:XLEN];
        end else if (div0) begin
            final_val = op_q[1] ? mcand : '1;
        end else if (op_q[1]) begin
            final_val = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end else begin
            final_val = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= '0;
            sign_a       <= 1'b0;
            sign_b       <= 1'b0;
            div0         <= 1'b0;
            mcand        <= '0;
            acc          <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= BUSY;
                        busy   <= 1'b1;
                        op_q   <= ALUOp[2:0];
                        sign_a <= sa;
                        sign_b <= sb;
                        div0   <= in_div & (op_b == '0);
                        // On divide-by-zero the raw dividend is kept for REM/REMU.
                        mcand  <= !in_div ? a_abs
                                : (op_b == '0) ? op_a : b_abs;
`ifdef MULDIV_FAST_MUL_EN
                        if (!in_div) begin
                            acc <= fast_prod;
                            cnt <= CW'(XLEN);
                        end else begin
                            acc <= {{XLEN{1'b0}}, a_abs};
                            cnt <= '0;
                        end
`else
                        acc <= {{XLEN{1'b0}}, in_div ? a_abs : b_abs};
                        cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CW'(XLEN)) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result       <= final_val;
                        result_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        acc <= op_q[2] ? div_next : mul_next;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
`timescale 1ns/1ps
module tb_muldiv_unit;
    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  ALUOp;
    logic [31:0] op_a, op_b;
    logic        flush;
    logic        busy, stall, result_valid;
    logic [31:0] result;

    int passed = 0;
    int total  = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .start(start), .ALUOp(ALUOp),
        .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy),
        .stall(stall), .result_valid(result_valid), .result(result)
    );

    always #5 clock = ~clock;

    task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output int bcnt, output bit ok);
        @(posedge clock); #1;
        ALUOp = op; op_a = a; op_b = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0; bcnt = 0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcnt++;
            @(posedge clock); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        total++;
        if ({busy, stall, result_valid} !== 3'b000 || result !== 32'h0)
            $display("FAIL reset_hold: busy=%b stall=%b rv=%b res=%h want 0",
                     busy, stall, result_valid, result);
        else passed++;
        reset = 1'b0;
        @(posedge clock); #1;
        total++;
        if ({busy, stall, result_valid} !== 3'b000 || result !== 32'h0)
            $display("FAIL reset_release: busy=%b stall=%b rv=%b res=%h want 0",
                     busy, stall, result_valid, result);
        else passed++;
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, bc; bit ok;
        @(posedge clock); #1;
        ALUOp = OP_MUL; op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1) $display("FAIL mul_stall_comb: got %b want 1", stall);
        else passed++;
        start = 1'b0;
        run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, r, lat, bc, ok);
        total++;
        if (!ok || r !== 32'hFFFF_FFEB)
            $display("FAIL mul_result: got %h ok=%0d want ffffffeb", r, ok);
        else passed++;
        total++;
        if (lat !== MUL_LAT) $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT);
        else passed++;
        total++;
        if (bc !== MUL_LAT) $display("FAIL mul_busy_cycles: got %0d want %0d", bc, MUL_LAT);
        else passed++;
        total++;
        if (stall !== 1'b0) $display("FAIL mul_stall_done: got %b want 0", stall);
        else passed++;
        @(posedge clock); #1;
        total++;
        if (result_valid !== 1'b0 || result !== 32'hFFFF_FFEB)
            $display("FAIL mul_pulse_width: rv=%b res=%h want 0/ffffffeb", result_valid, result);
        else passed++;
    endtask

    task automatic test_mulh();
        logic [4:0]  ops [3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] r; int lat, bc; bit ok;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat, bc, ok);
            total++;
            if (!ok || r !== ex[i])
                $display("FAIL mulh_%0d: got %h ok=%0d want %h", i, r, ok, ex[i]);
            else passed++;
        end
    endtask

    task automatic test_div();
        logic [4:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ex  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] r; int lat, bc; bit ok;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat, bc, ok);
            total++;
            if (!ok || r !== ex[i])
                $display("FAIL div_%0d: got %h ok=%0d want %h", i, r, ok, ex[i]);
            else passed++;
            total++;
            if (lat !== 33) $display("FAIL div_latency_%0d: got %0d want 33", i, lat);
            else passed++;
        end
    endtask

    task automatic test_div_edge();
        logic [4:0]  ops [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] r; int lat, bc; bit ok;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat, bc, ok);
            total++;
            if (!ok || r !== ex[i] || lat !== 33)
                $display("FAIL div_edge_%0d: got %h lat=%0d ok=%0d want %h lat=33",
                         i, r, lat, ok, ex[i]);
            else passed++;
        end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat, bc; bit ok, seen;
        run_op(OP_DIVU, 32'd100, 32'd7, r, lat, bc, ok);
        @(posedge clock); #1;
        ALUOp = OP_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || stall !== 1'b0)
            $display("FAIL flush_busy: busy=%b stall=%b want 0/0", busy, stall);
        else passed++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) seen = 1'b1;
            @(posedge clock); #1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL flush_no_pulse: got pulse want none");
        else passed++;
        total++;
        if (result !== 32'd14) $display("FAIL flush_result_hold: got %h want 0000000e", result);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        @(posedge clock); #1;
        ALUOp = OP_MUL; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        total++;
        if ({busy, stall, result_valid} !== 3'b000 || result !== 32'h0)
            $display("FAIL reset_mid_op: busy=%b stall=%b rv=%b res=%h want 0",
                     busy, stall, result_valid, result);
        else passed++;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        total++;
        if (result !== 32'h0 || busy !== 1'b0)
            $display("FAIL reset_discard: res=%h busy=%b want 0/0", result, busy);
        else passed++;
    endtask

    task automatic test_non_m();
        @(posedge clock); #1;
        ALUOp = OP_ADD; op_a = 32'd1; op_b = 32'd2; start = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) $display("FAIL non_m_stall: got %b want 0", stall);
        else passed++;
        @(posedge clock); #1;
        total++;
        if (busy !== 1'b0 || stall !== 1'b0)
            $display("FAIL non_m_busy: busy=%b stall=%b want 0/0", busy, stall);
        else passed++;
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat, bc, pulses; bit ok;
        run_op(OP_MUL, 32'd3, 32'd4, r, lat, bc, ok);
        total++;
        if (!ok || r !== 32'd12 || stall !== 1'b0)
            $display("FAIL b2b_first: got %h stall=%b ok=%0d want 0000000c/0", r, stall, ok);
        else passed++;
        ALUOp = OP_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        total++;
        if (stall !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0)
            $display("FAIL b2b_idle_gap: stall=%b busy=%b rv=%b want 1/0/0",
                     stall, busy, result_valid);
        else passed++;
        @(posedge clock); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b want 1", busy);
        else passed++;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (result_valid) begin
                pulses++;
                r = result;
            end
            @(posedge clock); #1;
        end
        total++;
        if (pulses !== 1 || r !== 32'd14)
            $display("FAIL b2b_second: pulses=%0d res=%h want 1/0000000e", pulses, r);
        else passed++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        ALUOp = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_edge();
        test_flush();
        test_reset_mid_op();
        test_non_m();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
